// File: rtl/alu_issue_seq.sv
// alu_issue_seq: command FIFO feeding a registered ALU stage with result handshake and accumulator.
// Optional ALU_ISSUE_OVF_TRAP_EN adds a sticky overflow trap that stalls issue until trap_clr.
module alu_issue_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_use_acc,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_y,
  input  logic                   alu_overflow,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   alu_negative,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
`ifdef ALU_ISSUE_OVF_TRAP_EN
  ,
  output logic                   ovf_trap,
  input  logic                   trap_clr
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * WIDTH + 4;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, y_q, y_d;
  logic [2:0] op_q, op_d;
  logic [3:0] fl_q, fl_d;
  logic ov_q, ov_d;
  logic push, pop, stall;
  logic head_acc;
  logic [2:0] head_op;
  logic [WIDTH-1:0] head_a, head_b;
  assign {head_acc, head_op, head_a, head_b} = mem_q[rd_q];
  assign in_ready = cnt_q != CW'(DEPTH);
  assign push = in_valid && in_ready;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign out_valid = ov_q;
  assign out_y = y_q;
  assign out_flags = fl_q;
  assign fifo_count = cnt_q;
  assign busy = state_q != IDLE || cnt_q != '0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic trap_q, trap_d;
  // a fresh overflow capture outranks a simultaneous clear
  assign trap_d = (state_q == EXEC && alu_overflow) || (trap_q && !trap_clr);
  assign stall = trap_q;
  assign ovf_trap = trap_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) trap_q <= 1'b0;
    else trap_q <= trap_d;
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    y_d = y_q;
    fl_d = fl_q;
    acc_d = acc_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: begin
        pop = cnt_q != '0 && !stall;
        state_d = pop ? EXEC : IDLE;
      end
      EXEC: begin
        y_d = alu_y;
        fl_d = {alu_overflow, alu_carry, alu_zero, alu_negative};
        acc_d = alu_y;
        ov_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (ov_q && out_ready) begin
        ov_d = 1'b0;
        pop = cnt_q != '0 && !stall;
        state_d = pop ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    a_d = pop ? (head_acc ? acc_q : head_a) : a_q;
    b_d = pop ? head_b : b_q;
    op_d = pop ? head_op : op_q;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_use_acc, in_op, in_a, in_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      acc_q <= '0;
      y_q <= '0;
      fl_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      acc_q <= acc_d;
      y_q <= y_d;
      fl_q <= fl_d;
      ov_q <= ov_d;
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: scoreboard bench for alu_issue_seq with a behavioural ALU closing the loop.
module tb_alu_issue_seq;
  logic clk, rst_n, in_valid, in_ready, in_use_acc;
  logic [2:0] in_op, alu_op;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_y, out_y;
  logic alu_overflow, alu_carry, alu_zero, alu_negative;
  logic out_valid, out_ready, busy;
  logic [3:0] out_flags;
  logic [2:0] fifo_count;
  logic ovf_trap, trap_clr;
  logic [11:0] sbq[$];
  int n_cmp = 0, n_bad = 0;

  alu_issue_seq #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags), .fifo_count(fifo_count), .busy(busy)
`ifdef ALU_ISSUE_OVF_TRAP_EN
    , .ovf_trap(ovf_trap), .trap_clr(trap_clr)
`endif
  );

`ifndef ALU_ISSUE_OVF_TRAP_EN
  assign ovf_trap = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_y = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: begin
        {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      3'd1: begin
        alu_y = alu_a - alu_b;
        alu_carry = alu_a < alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = alu_a << alu_b[2:0];
      3'd6: alu_y = alu_a >> alu_b[2:0];
      default: alu_y = $signed(alu_a) >>> alu_b[2:0];
    endcase
    alu_zero = alu_y == 8'd0;
    alu_negative = alu_y[7];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ua, input logic [7:0] ey, input logic [3:0] ef);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_use_acc = ua;
    sbq.push_back({ey, ef});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        logic [11:0] e;
        e = sbq.pop_front();
        chk("out_y", out_y, e[11:4]);
        chk("out_flags", out_flags, e[3:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    in_use_acc = 1'b0;
    out_ready = 1'b1;
    trap_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_regs", {alu_a, alu_b, alu_op}, 0);
    chk("rst_out", {out_y, out_flags}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // latency: accept at N, pop at N+1, out_valid after N+2
    send(3'd0, 8'd1, 8'd2, 1'b0, 8'd3, 4'b0000);
    chk("lat_n0_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_n1_valid", out_valid, 0);
    chk("lat_n1_busy", busy, 1);
    chk("lat_n1_alu", {alu_op, alu_a, alu_b}, {3'd0, 8'd1, 8'd2});
    @(negedge clk);
    chk("lat_n2_valid", out_valid, 1);
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    // accumulator chaining
    send(3'd0, 8'd5, 8'd3, 1'b0, 8'd8, 4'b0000);
    send(3'd1, 8'h55, 8'd8, 1'b1, 8'd0, 4'b0010);
    drain();
    // signed overflow and optional trap
    send(3'd0, 8'd127, 8'd1, 1'b0, 8'd128, 4'b1001);
    drain();
`ifdef ALU_ISSUE_OVF_TRAP_EN
    chk("trap_set", ovf_trap, 1);
    send(3'd2, 8'd255, 8'd15, 1'b0, 8'd15, 4'b0000);
    repeat (5) @(negedge clk);
    chk("trap_stall_valid", out_valid, 0);
    chk("trap_stall_count", fifo_count, 1);
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    drain();
    chk("trap_clr", ovf_trap, 0);
`else
    chk("no_trap", ovf_trap, 0);
    send(3'd2, 8'd255, 8'd15, 1'b0, 8'd15, 4'b0000);
    drain();
`endif
    // backpressure fills the FIFO
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(3'd4, 8'(i), 8'd0, 1'b0, 8'(i), 4'b0000);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", fifo_count, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("refill_in_ready", in_ready, 1);
    drain();
    // shifts
    send(3'd7, 8'h80, 8'd3, 1'b0, 8'hF0, 4'b0001);
    send(3'd5, 8'h01, 8'd7, 1'b0, 8'h80, 4'b0001);
    send(3'd6, 8'h80, 8'd7, 1'b0, 8'h01, 4'b0000);
    drain();
    // reset while a command is executing
    out_ready = 1'b0;
    send(3'd0, 8'd10, 8'd20, 1'b0, 8'd30, 4'b0000);
    send(3'd0, 8'd1, 8'd1, 1'b0, 8'd2, 4'b0000);
    send(3'd0, 8'd3, 8'd3, 1'b0, 8'd6, 4'b0000);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_quiet", out_valid, 0);
    send(3'd0, 8'hAA, 8'd2, 1'b1, 8'd2, 4'b0000);
    send(3'd0, 8'd2, 8'd2, 1'b0, 8'd4, 4'b0000);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
